// File: rtl/nfc_command_erase_multiplane.sv
// Multi-plane block erase command sequencer.
// Issues 60h / row address / D1h-or-D0h per plane through the command/address
// primitive, optionally waits on R/B after each confirm, then pulses oLastStep.
module nfc_command_erase_multiplane #(
    parameter int         NumberOfWays  = 4,
    parameter logic [5:0] CommandID     = 6'b000111,
    parameter int         MaxPlanes     = 4,
    parameter int         RowAddrBytes  = 3,
    parameter int         PageBits      = 7,
    parameter bit         WaitReadyBusy = 1'b1,
    parameter int         RBLowTimeout  = 16
) (
    input  logic                    iSystemClock,
    input  logic                    iReset,
    input  logic [5:0]              iOpcode,
    input  logic [4:0]              iTargetID,
    input  logic                    iCMDValid,
    output logic                    oCMDReady,
    input  logic [NumberOfWays-1:0] iWaySelect,
    input  logic [23:0]             iRowAddress,
    input  logic [1:0]              iPlaneCount,
    output logic                    oStart,
    output logic                    oLastStep,
    output logic [7:0]              oACG_Command,
    output logic [2:0]              oACG_CommandOption,
    input  logic [7:0]              iACG_Ready,
    input  logic [7:0]              iACG_LastStep,
    output logic [NumberOfWays-1:0] oACG_TargetWay,
    output logic [15:0]             oACG_NumOfData,
    output logic                    oACG_CASelect,
    output logic [39:0]             oACG_CAData,
    input  logic [NumberOfWays-1:0] iACG_ReadyBusy
);

    localparam logic [1:0]  MaxPlaneIdx  = 2'(MaxPlanes - 1);
    localparam logic [23:0] PageMask     = ~((24'd1 << PageBits) - 24'd1);
    localparam logic [15:0] AddrCount    = 16'(RowAddrBytes - 1);
    localparam logic [8:0]  TimeoutLimit = 9'(RBLowTimeout);

    typedef enum logic [3:0] {
        READY, LATCH, CMD1, ADDR, CMD2, GAP, WAITLOW, WAITHIGH, DONE
    } stateType;

    stateType                state, nextState, gapFrom, nextGapFrom;
    logic [1:0]              planeIdx, nextPlane, lastPlane;
    logic [NumberOfWays-1:0] wayReg;
    logic [23:0]             rowReg;
    logic [4:0]              targetIdReg;
    logic [7:0]              timeoutCnt;
    logic                    rbSync1, rbSync2;
    logic                    finalPlane, timeoutHit, stepDone;
    logic [23:0]             rowNext;
    logic [7:0]              cmdNext;
    logic                    caSelNext;
    logic [15:0]             numDataNext;
    logic [39:0]             caDataNext;
    logic                    unusedInputs;

    assign oStart             = (iOpcode == CommandID) && iCMDValid && oCMDReady;
    assign oACG_CommandOption = 3'b000;
    assign finalPlane         = (planeIdx == lastPlane);
    assign timeoutHit         = ({1'b0, timeoutCnt} + 9'd1) >= TimeoutLimit;
    assign stepDone           = iACG_LastStep[3];
    assign rowNext            = (rowReg + (24'(nextPlane) << PageBits)) & PageMask;
    assign unusedInputs       = ^{iACG_Ready, iACG_LastStep[7:4], iACG_LastStep[2:0],
                                  targetIdReg, rowNext[23:16]};

    // State, plane index and return-point register
    always_ff @(posedge iSystemClock) begin
        if (iReset) begin
            state    <= READY;
            gapFrom  <= READY;
            planeIdx <= 2'd0;
        end else begin
            state    <= nextState;
            gapFrom  <= nextGapFrom;
            planeIdx <= nextPlane;
        end
    end

    // Next-state logic plus the primitive request that belongs to the next state
    always_comb begin
        nextState   = state;
        nextPlane   = planeIdx;
        nextGapFrom = gapFrom;
        case (state)
            READY: begin
                if (oStart) begin
                    nextState = LATCH;
                    nextPlane = 2'd0;
                end
            end
            LATCH: nextState = CMD1;
            CMD1, ADDR, CMD2: begin
                if (stepDone) begin
                    nextState   = GAP;
                    nextGapFrom = state;
                end
            end
            GAP: begin
                case (gapFrom)
                    CMD1: nextState = ADDR;
                    ADDR: nextState = CMD2;
                    default: begin
                        if (WaitReadyBusy) begin
                            nextState = WAITLOW;
                        end else if (finalPlane) begin
                            nextState = DONE;
                        end else begin
                            nextState = CMD1;
                            nextPlane = planeIdx + 2'd1;
                        end
                    end
                endcase
            end
            WAITLOW: begin
                if (!rbSync2 || timeoutHit) nextState = WAITHIGH;
            end
            WAITHIGH: begin
                if (rbSync2) begin
                    if (finalPlane) begin
                        nextState = DONE;
                    end else begin
                        nextState = CMD1;
                        nextPlane = planeIdx + 2'd1;
                    end
                end
            end
            DONE:    nextState = READY;
            default: nextState = READY;
        endcase

        cmdNext     = 8'h00;
        caSelNext   = 1'b1;
        numDataNext = 16'd0;
        caDataNext  = 40'd0;
        case (nextState)
            CMD1: begin
                cmdNext    = 8'h08;
                caDataNext = 40'h60_00_00_00_00;
            end
            ADDR: begin
                cmdNext     = 8'h08;
                caSelNext   = 1'b0;
                numDataNext = AddrCount;
                if (RowAddrBytes == 2) begin
                    caDataNext = {rowNext[7:0], rowNext[15:8], 24'h0};
                end else begin
                    caDataNext = {rowNext[7:0], rowNext[15:8], rowNext[23:16], 16'h0};
                end
            end
            CMD2: begin
                cmdNext    = 8'h08;
                caDataNext = (nextPlane == lastPlane) ? 40'hD0_00_00_00_00 : 40'hD1_00_00_00_00;
            end
            default: ;
        endcase
    end

    // Registered outputs so every output lines up with the state it belongs to
    always_ff @(posedge iSystemClock) begin
        if (iReset) begin
            oCMDReady      <= 1'b1;
            oLastStep      <= 1'b0;
            oACG_Command   <= 8'h00;
            oACG_CASelect  <= 1'b1;
            oACG_NumOfData <= 16'd0;
            oACG_CAData    <= 40'd0;
        end else begin
            oCMDReady      <= (nextState == READY);
            oLastStep      <= (nextState == DONE);
            oACG_Command   <= cmdNext;
            oACG_CASelect  <= caSelNext;
            oACG_NumOfData <= numDataNext;
            oACG_CAData    <= caDataNext;
        end
    end

    // Command field capture, WAITLOW cycle counter and two-stage R/B sampler
    always_ff @(posedge iSystemClock) begin
        if (iReset) begin
            wayReg         <= '0;
            rowReg         <= 24'd0;
            lastPlane      <= 2'd0;
            targetIdReg    <= 5'd0;
            oACG_TargetWay <= '0;
            timeoutCnt     <= 8'd0;
            rbSync1        <= 1'b0;
            rbSync2        <= 1'b0;
        end else begin
            if (oStart) begin
                wayReg         <= iWaySelect;
                rowReg         <= iRowAddress;
                lastPlane      <= (iPlaneCount > MaxPlaneIdx) ? MaxPlaneIdx : iPlaneCount;
                targetIdReg    <= iTargetID;
                oACG_TargetWay <= ~iWaySelect;
            end
            timeoutCnt <= (state == WAITLOW) ? timeoutCnt + 8'd1 : 8'd0;
            rbSync1    <= |(wayReg & iACG_ReadyBusy);
            rbSync2    <= rbSync1;
        end
    end

endmodule

// File: tb/tb_nfc_command_erase_multiplane.sv
// Randomized bench for the multi-plane erase sequencer.
// Unit 0: default build (R/B wait, 3 row bytes, 4 planes).
// Unit 1: no R/B wait, 2 row bytes, at most 3 planes.
module tb_nfc_command_erase_multiplane;

    localparam int         NumUnits   = 2;
    localparam logic [5:0] EraseOp    = 6'b000111;
    localparam int         PageBits   = 7;
    localparam int         EventBound = 60;

    int unitWRB[NumUnits]       = '{1, 0};
    int unitRAB[NumUnits]       = '{3, 2};
    int unitMaxPlanes[NumUnits] = '{4, 3};

    typedef struct {
        logic        caSel;
        logic [15:0] numData;
        logic [39:0] data;
        bit          isConfirm;
    } beatType;

    beatType expQ[$];
    int errorCount = 0;
    int checkCount = 0;
    int lastStepSeen[NumUnits] = '{0, 0};

    logic iSystemClock = 1'b0;
    always #5 iSystemClock = ~iSystemClock;

    logic        resetV[NumUnits];
    logic [5:0]  opcodeV[NumUnits];
    logic [4:0]  targetV[NumUnits];
    logic        validV[NumUnits];
    logic [3:0]  wayV[NumUnits];
    logic [23:0] rowV[NumUnits];
    logic [1:0]  pcV[NumUnits];
    logic [7:0]  readyV[NumUnits];
    logic [7:0]  lastStepInV[NumUnits];
    logic [3:0]  rbV[NumUnits];
    logic        cmdReadyV[NumUnits];
    logic        startV[NumUnits];
    logic        lastStepV[NumUnits];
    logic [7:0]  acgCmdV[NumUnits];
    logic [2:0]  optV[NumUnits];
    logic [3:0]  targetWayV[NumUnits];
    logic [15:0] nodV[NumUnits];
    logic        caSelV[NumUnits];
    logic [39:0] caDataV[NumUnits];

    for (genvar g = 0; g < NumUnits; g++) begin : units
        nfc_command_erase_multiplane #(
            .NumberOfWays(4), .CommandID(EraseOp), .MaxPlanes(g == 0 ? 4 : 3),
            .RowAddrBytes(g == 0 ? 3 : 2), .PageBits(PageBits),
            .WaitReadyBusy(g == 0), .RBLowTimeout(16)
        ) dut (
            .iSystemClock(iSystemClock), .iReset(resetV[g]), .iOpcode(opcodeV[g]),
            .iTargetID(targetV[g]), .iCMDValid(validV[g]), .oCMDReady(cmdReadyV[g]),
            .iWaySelect(wayV[g]), .iRowAddress(rowV[g]), .iPlaneCount(pcV[g]),
            .oStart(startV[g]), .oLastStep(lastStepV[g]), .oACG_Command(acgCmdV[g]),
            .oACG_CommandOption(optV[g]), .iACG_Ready(readyV[g]),
            .iACG_LastStep(lastStepInV[g]), .oACG_TargetWay(targetWayV[g]),
            .oACG_NumOfData(nodV[g]), .oACG_CASelect(caSelV[g]), .oACG_CAData(caDataV[g]),
            .iACG_ReadyBusy(rbV[g])
        );
    end

    // Count completion pulses away from the active edge
    always @(negedge iSystemClock) begin
        for (int u = 0; u < NumUnits; u++) begin
            if (lastStepV[u] === 1'b1) lastStepSeen[u]++;
        end
    end

    task automatic checkOutput(input string tag, input logic [39:0] observed, input logic [39:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge iSystemClock);
        #1;
    endtask

    // Reference: the primitive transactions one erase command must produce
    task automatic buildExpected(input int u, input logic [23:0] row, input logic [1:0] pc);
        int          planes;
        int unsigned rv;
        logic [7:0]  b0, b1, b2;
        beatType     bt;
        expQ.delete();
        planes = int'(pc) + 1;
        if (planes > unitMaxPlanes[u]) planes = unitMaxPlanes[u];
        for (int p = 0; p < planes; p++) begin
            rv = (int'({8'h00, row}) + p * (1 << PageBits)) % (1 << 24);
            rv = rv - (rv % (1 << PageBits));
            b0 = 8'(rv);
            b1 = 8'(rv >> 8);
            b2 = 8'(rv >> 16);
            bt.caSel = 1'b1; bt.numData = 16'd0; bt.data = 40'h60_00_00_00_00; bt.isConfirm = 1'b0;
            expQ.push_back(bt);
            bt.caSel = 1'b0;
            if (unitRAB[u] == 3) begin
                bt.numData = 16'd2;
                bt.data    = {b0, b1, b2, 16'h0};
            end else begin
                bt.numData = 16'd1;
                bt.data    = {b0, b1, 24'h0};
            end
            expQ.push_back(bt);
            bt.caSel = 1'b1; bt.numData = 16'd0; bt.isConfirm = 1'b1;
            bt.data  = (p == planes - 1) ? 40'hD0_00_00_00_00 : 40'hD1_00_00_00_00;
            expQ.push_back(bt);
        end
    endtask

    task automatic waitEvent(input int u, output int n, output bit hit);
        n   = 0;
        hit = 1'b0;
        while (!hit && n < EventBound) begin
            tick();
            n++;
            if (acgCmdV[u] === 8'h08 || lastStepV[u] === 1'b1) hit = 1'b1;
        end
        if (!hit) checkOutput("eventTimeout", 40'd0, 40'd1);
    endtask

    task automatic checkResetState(input int u);
        checkOutput("rstReady",   40'(cmdReadyV[u]),  40'd1);
        checkOutput("rstLast",    40'(lastStepV[u]),  40'd0);
        checkOutput("rstCmd",     40'(acgCmdV[u]),    40'd0);
        checkOutput("rstOpt",     40'(optV[u]),       40'd0);
        checkOutput("rstWay",     40'(targetWayV[u]), 40'd0);
        checkOutput("rstNod",     40'(nodV[u]),       40'd0);
        checkOutput("rstCaSel",   40'(caSelV[u]),     40'd1);
        checkOutput("rstCaData",  caDataV[u],         40'd0);
    endtask

    task automatic applyStimulus(input int u, input logic [5:0] op, input logic [23:0] row,
                                 input logic [1:0] pc, input logic [3:0] way, output bit accepted);
        int n;
        logic [3:0] expWay;
        n = 0;
        while (cmdReadyV[u] !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) checkOutput("readyTimeout", 40'd0, 40'd1);
        opcodeV[u] = op; rowV[u] = row; pcV[u] = pc; wayV[u] = way;
        targetV[u] = 5'($urandom); validV[u] = 1'b1;
        #1;
        accepted = (op == EraseOp);
        checkOutput("start", 40'(startV[u]), 40'(accepted));
        tick();
        validV[u] = 1'b0;
        rowV[u] = 24'($urandom); pcV[u] = 2'($urandom); wayV[u] = 4'($urandom);
        expWay = ~way;
        if (accepted) begin
            checkOutput("busyFlag", 40'(cmdReadyV[u]), 40'd0);
            checkOutput("latchWay", 40'(targetWayV[u]), 40'(expWay));
        end else begin
            checkOutput("stillIdle", 40'(cmdReadyV[u]), 40'd1);
            checkOutput("idleCmd", 40'(acgCmdV[u]), 40'd0);
        end
    endtask

    task automatic runSequence(input int u, input logic [3:0] way, input bit rbMode,
                               input bit busyPoke, output bit ok);
        int n, lsBefore, lowLen;
        bit hit, early;
        beatType bt;
        logic [3:0] expWay;
        ok = 1'b1;
        expWay = ~way;
        lsBefore = lastStepSeen[u];
        waitEvent(u, n, hit);
        if (!hit) begin ok = 1'b0; return; end
        checkOutput("latchToCmd1", 40'(n), 40'd1);
        for (int i = 0; i < expQ.size(); i++) begin
            bt = expQ[i];
            checkOutput("issueCmd", 40'(acgCmdV[u]), 40'h08);
            checkOutput("caSel", 40'(caSelV[u]), 40'(bt.caSel));
            checkOutput("numData", 40'(nodV[u]), 40'(bt.numData));
            checkOutput("caData", caDataV[u], bt.data);
            checkOutput("targetWay", 40'(targetWayV[u]), 40'(expWay));
            if (busyPoke && bt.isConfirm) begin
                opcodeV[u] = EraseOp; validV[u] = 1'b1; rowV[u] = 24'($urandom);
                #1;
                checkOutput("busyStart", 40'(startV[u]), 40'd0);
                validV[u] = 1'b0;
            end
            repeat ($urandom_range(0, 3)) tick();
            checkOutput("holdData", caDataV[u], bt.data);
            if (bt.isConfirm && unitWRB[u] == 1 && !rbMode) rbV[u] = 4'($urandom) | way;
            lastStepInV[u] = 8'($urandom) | 8'h08;
            tick();
            lastStepInV[u] = 8'h00;
            checkOutput("gapCmd", 40'(acgCmdV[u]), 40'd0);
            if (bt.isConfirm && unitWRB[u] == 1) begin
                if (!rbMode) begin
                    waitEvent(u, n, hit);
                    checkOutput("timeoutPath", 40'(n), 40'd18);
                end else begin
                    repeat ($urandom_range(0, 3)) tick();
                    rbV[u] = 4'($urandom) & ~way;
                    lastStepInV[u] = 8'h08;
                    early = 1'b0;
                    lowLen = $urandom_range(3, 8);
                    for (int k = 0; k < lowLen; k++) begin
                        tick();
                        lastStepInV[u] = 8'h00;
                        if (acgCmdV[u] === 8'h08 || lastStepV[u] === 1'b1) early = 1'b1;
                    end
                    rbV[u] = 4'hF;
                    waitEvent(u, n, hit);
                    checkOutput("rbWaitHeld", 40'(early), 40'd0);
                    checkOutput("rbToNext", 40'(n), 40'd3);
                end
                rbV[u] = 4'hF;
            end else begin
                waitEvent(u, n, hit);
                checkOutput("gapLen", 40'(n), 40'd1);
            end
            if (!hit) begin ok = 1'b0; return; end
            if (i == expQ.size() - 1) begin
                checkOutput("lastStepPulse", 40'(lastStepV[u]), 40'd1);
                checkOutput("doneCmd", 40'(acgCmdV[u]), 40'd0);
            end else begin
                checkOutput("noEarlyDone", 40'(lastStepV[u]), 40'd0);
            end
        end
        tick();
        checkOutput("lastStepOnce", 40'(lastStepV[u]), 40'd0);
        checkOutput("readyBack", 40'(cmdReadyV[u]), 40'd1);
        checkOutput("lastStepCount", 40'(lastStepSeen[u] - lsBefore), 40'd1);
    endtask

    task automatic runCommand(input int u, input logic [5:0] op, input logic [23:0] row,
                              input logic [1:0] pc, input logic [3:0] way, input bit rbMode,
                              input bit busyPoke);
        bit acc, ok;
        applyStimulus(u, op, row, pc, way, acc);
        if (!acc) return;
        buildExpected(u, row, pc);
        runSequence(u, way, rbMode, busyPoke, ok);
        if (!ok) begin
            lastStepInV[u] = 8'h00; rbV[u] = 4'hF; resetV[u] = 1'b1;
            tick();
            resetV[u] = 1'b0;
        end
    endtask

    task automatic resetMidAddr(input int u);
        bit acc, hit;
        int n, lsBefore;
        logic [3:0] way;
        way = 4'(1 << $urandom_range(0, 3));
        applyStimulus(u, EraseOp, 24'($urandom), 2'($urandom), way, acc);
        waitEvent(u, n, hit);
        lastStepInV[u] = 8'h08;
        tick();
        lastStepInV[u] = 8'h00;
        waitEvent(u, n, hit);
        checkOutput("addrPhase", 40'(caSelV[u]), 40'd0);
        lsBefore = lastStepSeen[u];
        resetV[u] = 1'b1;
        tick();
        resetV[u] = 1'b0;
        checkResetState(u);
        runCommand(u, EraseOp, 24'($urandom), 2'($urandom), 4'(1 << $urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'b0);
        checkOutput("noLastStepOnReset", 40'(lastStepSeen[u] - lsBefore), 40'd1);
    endtask

    // Bound the whole run in case the design stalls somewhere unexpected
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int u = 0; u < NumUnits; u++) begin
            resetV[u] = 1'b1; opcodeV[u] = 6'd0; targetV[u] = 5'd0; validV[u] = 1'b0;
            wayV[u] = 4'd0; rowV[u] = 24'd0; pcV[u] = 2'd0; readyV[u] = 8'hFF;
            lastStepInV[u] = 8'h00; rbV[u] = 4'hF;
        end
        repeat (3) tick();
        for (int u = 0; u < NumUnits; u++) checkResetState(u);
        for (int u = 0; u < NumUnits; u++) resetV[u] = 1'b0;
        tick();

        for (int u = 0; u < NumUnits; u++) begin
            lastStepInV[u] = 8'h08;
            tick();
            lastStepInV[u] = 8'h00;
            tick();
            checkOutput("idleStray", 40'(acgCmdV[u]), 40'd0);
            checkOutput("idleStrayReady", 40'(cmdReadyV[u]), 40'd1);
        end

        runCommand(1, EraseOp, 24'h01_23_C5, 2'd0, 4'b0001, 1'b0, 1'b0);
        runCommand(0, EraseOp, 24'h01_23_C5, 2'd0, 4'b0010, 1'b0, 1'b0);
        runCommand(0, EraseOp, 24'h12_34_56, 2'd3, 4'b0100, 1'b1, 1'b0);
        runCommand(0, EraseOp, 24'hFF_FF_80, 2'd1, 4'b1000, 1'b1, 1'b1);
        runCommand(1, EraseOp, 24'hFF_FF_80, 2'd3, 4'b0010, 1'b0, 1'b1);
        runCommand(1, 6'b000110, 24'h00_10_00, 2'd1, 4'b0001, 1'b0, 1'b0);
        resetMidAddr(0);
        resetMidAddr(1);

        for (int k = 0; k < 24; k++) begin
            int u;
            logic [5:0] op;
            u  = $urandom_range(0, 1);
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : EraseOp;
            runCommand(u, op, 24'($urandom), 2'($urandom), 4'(1 << $urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (4) tick();
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
